// File: rtl/game_pkg.sv
// Shared game definitions: action codes and the
// answer checker state encoding.
package game_pkg;

  localparam int ACT_NONE   = 0;
  localparam int ACT_TOGGLE = 1;
  localparam int ACT_PUSH   = 2;
  localparam int ACT_MIC    = 3;
  localparam int ACT_MOUSE  = 4;

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_COLLECT,
    CHK_COMPARE,
    CHK_RESULT
  } chk_state_e;

  function automatic logic is_action(int c);
    return (c == ACT_TOGGLE) || (c == ACT_PUSH) ||
           (c == ACT_MIC) || (c == ACT_MOUSE);
  endfunction

endpackage

// File: rtl/answer_checker_if.sv
// Bus between decode/control and the answer checker.
// master drives level, actions and fetch_check;
// slave returns check/check_done, user_count, overflow
// (and live_miss when CHECK_LIVE_MISMATCH_EN is defined).
interface answer_checker_if #(
  parameter int MAX_LEN = 16,
  parameter int CODE_W  = 3
);
  localparam int CW = $clog2(MAX_LEN + 1);

  logic                      level_load;
  logic [MAX_LEN*CODE_W-1:0] expected_seq;
  logic [CW-1:0]             expected_len;
  logic                      action_valid;
  logic [CODE_W-1:0]         action_code;
  logic                      fetch_check;
  logic                      check_done;
  logic                      check;
  logic [CW-1:0]             user_count;
  logic                      overflow;
`ifdef CHECK_LIVE_MISMATCH_EN
  logic                      live_miss;
`endif

  modport master (
`ifdef CHECK_LIVE_MISMATCH_EN
    input  live_miss,
`endif
    output level_load,
    output expected_seq,
    output expected_len,
    output action_valid,
    output action_code,
    output fetch_check,
    input  check_done,
    input  check,
    input  user_count,
    input  overflow
  );

  modport slave (
`ifdef CHECK_LIVE_MISMATCH_EN
    output live_miss,
`endif
    input  level_load,
    input  expected_seq,
    input  expected_len,
    input  action_valid,
    input  action_code,
    input  fetch_check,
    output check_done,
    output check,
    output user_count,
    output overflow
  );

endinterface

// File: rtl/action_buffer.sv
// Player action store: DEPTH x W registers, write pointer,
// full flag, asynchronous read. Ports: clr_i, wr_i/wr_data_i,
// rd_idx_i/rd_data_o, count_o, full_o.
module action_buffer #(
  parameter int DEPTH = 16,
  parameter int W     = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic [CW-1:0] rd_idx_i,
  output logic [W-1:0]  rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q;

  assign full_o  = cnt_q == CW'(DEPTH);
  assign count_o = cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (wr_i && !full_o) begin
      mem_q[cnt_q[AW-1:0]] <= wr_data_i;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Indexes at or past DEPTH read as zero.
  assign rd_data_o = (rd_idx_i < CW'(DEPTH)) ?
                     mem_q[rd_idx_i[AW-1:0]] : '0;

endmodule

// File: rtl/answer_checker.sv
// Collects player actions and compares them to the level
// sequence on fetch_check. Ports: clock, reset (async low),
// io (answer_checker_if.slave). Option: CHECK_LIVE_MISMATCH_EN
// adds io.live_miss, a per-action mismatch pulse.
module answer_checker
  import game_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int CODE_W  = 3
) (
  input  logic             clock,
  input  logic             reset,
  answer_checker_if.slave  io
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  chk_state_e        state_q, state_d;
  logic [CW-1:0]     len_q, idx_q, cnt;
  logic [CODE_W-1:0] exp_q [MAX_LEN];
  logic [CODE_W-1:0] rd_data;
  logic              ovf_q, check_q, full;
  logic              code_ok, wr;
  logic              imm_fail, at_end, miss, cmp_done;

  assign code_ok = is_action(int'(io.action_code));

  assign wr = !io.level_load && state_q == CHK_COLLECT &&
              io.action_valid && code_ok && !full;

  action_buffer #(
    .DEPTH (MAX_LEN),
    .W     (CODE_W),
    .CW    (CW)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (io.level_load),
    .wr_i      (wr),
    .wr_data_i (io.action_code),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_data),
    .count_o   (cnt),
    .full_o    (full)
  );

  // Length or overflow errors fail without walking the buffer.
  assign imm_fail = (cnt != len_q) || ovf_q;
  assign at_end   = idx_q == len_q;
  assign miss     = !at_end &&
                    rd_data != exp_q[idx_q[AW-1:0]];
  assign cmp_done = imm_fail || miss || at_end;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= CHK_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (io.level_load) begin
      state_d = CHK_COLLECT;
    end else begin
      unique case (state_q)
        CHK_IDLE:    state_d = CHK_IDLE;
        CHK_COLLECT: if (io.fetch_check) state_d = CHK_COMPARE;
        CHK_COMPARE: if (cmp_done) state_d = CHK_RESULT;
        CHK_RESULT:  state_d = CHK_COLLECT;
        default:     state_d = CHK_IDLE;
      endcase
    end
  end

  always_comb begin
    io.check_done = state_q == CHK_RESULT;
    io.check      = check_q;
    io.user_count = cnt;
    io.overflow   = ovf_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      check_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) exp_q[i] <= '0;
    end else if (io.level_load) begin
      len_q   <= (io.expected_len > CW'(MAX_LEN)) ?
                 CW'(MAX_LEN) : io.expected_len;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      check_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++)
        exp_q[i] <= io.expected_seq[i*CODE_W +: CODE_W];
    end else begin
      unique case (state_q)
        CHK_COLLECT: begin
          if (io.action_valid && code_ok && full)
            ovf_q <= 1'b1;
          if (io.fetch_check) begin
            idx_q   <= '0;
            check_q <= 1'b0;
          end
        end
        CHK_COMPARE: begin
          if (cmp_done) check_q <= !imm_fail && !miss;
          else          idx_q   <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CHECK_LIVE_MISMATCH_EN
  logic live_q;

  // Flags a stored action that is wrong for its slot or
  // lands beyond the expected length.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) live_q <= 1'b0;
    else live_q <= wr && ((cnt >= len_q) ||
                   io.action_code != exp_q[cnt[AW-1:0]]);
  end

  assign io.live_miss = live_q;
`endif

endmodule
